// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage bus: instruction memory, redirect and decode handshakes
interface fetch_unit_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_valid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        ins_valid_o;
  logic        ins_ready_i;
  logic [31:0] instruction_o;
  logic [31:0] pc_o;
  logic        misaligned_o;
  logic [31:0] fetch_count_o;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_valid_i,
    input  imem_rdata_i,
    input  redirect_i,
    input  redirect_pc_i,
    output ins_valid_o,
    input  ins_ready_i,
    output instruction_o,
    output pc_o,
    output misaligned_o,
    output fetch_count_o
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_valid_i,
    output imem_rdata_i,
    output redirect_i,
    output redirect_pc_i,
    input  ins_valid_o,
    output ins_ready_i,
    input  instruction_o,
    input  pc_o,
    input  misaligned_o,
    input  fetch_count_o
  );
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I fetch stage: PC ownership, imem request/valid, decode valid/ready, redirects
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSN = 32'h0000_0013
) (
  input  logic clk_i,
  input  logic reset_i,
  fetch_unit_if.master bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_HOLD  = 3'd2;
  localparam logic [2:0] S_FLUSH = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  logic [2:0]  state;
  logic [31:0] pc;
  logic [31:0] pending_pc;
  logic [31:0] instruction_q;
  logic [31:0] pc_q;
  logic        ins_valid_q;
  logic        misaligned_q;
  logic [31:0] fetch_count_q;

  logic        target_bad;
  logic        mem_valid;

  assign target_bad = (bus.redirect_pc_i[1:0] != 2'b00);
  // The memory response only means something while a request is outstanding.
  assign mem_valid  = bus.imem_valid_i && ((state == S_FETCH) || (state == S_FLUSH));

  assign bus.imem_req_o    = (state == S_FETCH) || (state == S_FLUSH);
  assign bus.imem_addr_o   = pc;
  assign bus.ins_valid_o   = ins_valid_q;
  assign bus.instruction_o = instruction_q;
  assign bus.pc_o          = pc_q;
  assign bus.misaligned_o  = misaligned_q;
  assign bus.fetch_count_o = fetch_count_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state         <= S_IDLE;
      pc            <= RESET_PC;
      pending_pc    <= RESET_PC;
      instruction_q <= NOP_INSN;
      pc_q          <= RESET_PC;
      ins_valid_q   <= 1'b0;
      misaligned_q  <= 1'b0;
      fetch_count_q <= 32'd0;
    end else if (state == S_FAULT) begin
      ins_valid_q   <= 1'b0;
      instruction_q <= NOP_INSN;
      misaligned_q  <= 1'b1;
    end else if (bus.redirect_i && target_bad) begin
      state         <= S_FAULT;
      ins_valid_q   <= 1'b0;
      instruction_q <= NOP_INSN;
      misaligned_q  <= 1'b1;
    end else if (bus.redirect_i) begin
      // A redirect kills whatever is held and steers the next fetch.
      if (state == S_HOLD) begin
        ins_valid_q   <= 1'b0;
        instruction_q <= NOP_INSN;
        pc            <= bus.redirect_pc_i;
        state         <= S_FETCH;
      end else if ((state == S_FETCH) || (state == S_FLUSH)) begin
        if (mem_valid) begin
          pc    <= bus.redirect_pc_i;
          state <= S_FETCH;
        end else begin
          pending_pc <= bus.redirect_pc_i;
          state      <= S_FLUSH;
        end
      end else begin
        pc    <= bus.redirect_pc_i;
        state <= S_FETCH;
      end
    end else begin
      case (state)
        S_IDLE: begin
          state <= S_FETCH;
        end
        S_FETCH: begin
          if (mem_valid) begin
            instruction_q <= bus.imem_rdata_i;
            pc_q          <= pc;
            ins_valid_q   <= 1'b1;
            state         <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (bus.ins_ready_i) begin
            ins_valid_q   <= 1'b0;
            instruction_q <= NOP_INSN;
            pc            <= pc + 32'd4;
            fetch_count_q <= fetch_count_q + 32'd1;
            state         <= S_FETCH;
          end
        end
        S_FLUSH: begin
          // The stale response at the old address is dropped here.
          if (mem_valid) begin
            pc    <= pending_pc;
            state <= S_FETCH;
          end
        end
        default: begin
          state <= S_FAULT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed table and sequence checks for fetch_unit
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk_i = 1'b0;
  logic reset_i = 1'b1;
  int   total = 0;
  int   bad = 0;
  int   mem_lat = 0;
  int   wait_cnt;

  fetch_unit_if bus ();

  fetch_unit dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .bus     (bus)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA5A5_0013;
  endfunction

  always @(posedge clk_i or posedge reset_i) begin
    if (reset_i) wait_cnt <= 0;
    else if (!bus.imem_req_o || bus.imem_valid_i) wait_cnt <= 0;
    else wait_cnt <= wait_cnt + 1;
  end

  assign bus.imem_valid_i = bus.imem_req_o && (wait_cnt >= mem_lat);
  assign bus.imem_rdata_i = mem_word(bus.imem_addr_o);

  typedef struct {
    logic        rd;
    logic [31:0] rpc;
    logic        rdy;
    logic        req;
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
    logic [31:0] cnt;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic rd, input logic [31:0] rpc, input logic rdy,
                     input logic req, input logic [31:0] addr, input logic vld,
                     input logic [31:0] pc, input logic [31:0] cnt);
    vec_t v;
    v.rd = rd; v.rpc = rpc; v.rdy = rdy; v.req = req;
    v.addr = addr; v.vld = vld; v.pc = pc; v.cnt = cnt;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    bus.redirect_i = 1'b0;
    bus.redirect_pc_i = 32'h0;
    bus.ins_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    reset_i = 1'b0;
  endtask

  task automatic wait_valid(input int max_cycles);
    int n;
    n = 0;
    while (!bus.ins_valid_o && n < max_cycles) begin
      tick();
      n++;
    end
    chk("wait_valid", {31'd0, bus.ins_valid_o}, 32'd1);
  endtask

  initial begin
    do_reset();
    chk("rst_req", {31'd0, bus.imem_req_o}, 32'd0);
    chk("rst_addr", bus.imem_addr_o, 32'h0);
    chk("rst_valid", {31'd0, bus.ins_valid_o}, 32'd0);
    chk("rst_insn", bus.instruction_o, NOP);
    chk("rst_pc", bus.pc_o, 32'h0);
    chk("rst_mis", {31'd0, bus.misaligned_o}, 32'd0);
    chk("rst_cnt", bus.fetch_count_o, 32'd0);

    // zero-wait stream, 5-cycle stall, redirect in HOLD with ready high
    add(0, 0, 1, 1, 32'h00, 0, 32'h00, 0);
    add(0, 0, 1, 0, 32'h00, 1, 32'h00, 0);
    add(0, 0, 1, 1, 32'h04, 0, 32'h00, 1);
    add(0, 0, 1, 0, 32'h04, 1, 32'h04, 1);
    add(0, 0, 1, 1, 32'h08, 0, 32'h04, 2);
    add(0, 0, 1, 0, 32'h08, 1, 32'h08, 2);
    add(0, 0, 1, 1, 32'h0C, 0, 32'h08, 3);
    add(0, 0, 1, 0, 32'h0C, 1, 32'h0C, 3);
    add(0, 0, 1, 1, 32'h10, 0, 32'h0C, 4);
    add(0, 0, 0, 0, 32'h10, 1, 32'h10, 4);
    for (int i = 0; i < 5; i++) add(0, 0, 0, 0, 32'h10, 1, 32'h10, 4);
    add(0, 0, 1, 1, 32'h14, 0, 32'h10, 5);
    add(0, 0, 1, 0, 32'h14, 1, 32'h14, 5);
    add(1, 32'h40, 1, 1, 32'h40, 0, 32'h14, 5);
    add(0, 0, 1, 0, 32'h40, 1, 32'h40, 5);
    add(0, 0, 1, 1, 32'h44, 0, 32'h40, 6);

    for (int i = 0; i < vq.size(); i++) begin
      bus.redirect_i    = vq[i].rd;
      bus.redirect_pc_i = vq[i].rpc;
      bus.ins_ready_i   = vq[i].rdy;
      tick();
      chk($sformatf("v%0d_req", i), {31'd0, bus.imem_req_o}, {31'd0, vq[i].req});
      chk($sformatf("v%0d_valid", i), {31'd0, bus.ins_valid_o}, {31'd0, vq[i].vld});
      chk($sformatf("v%0d_cnt", i), bus.fetch_count_o, vq[i].cnt);
      chk($sformatf("v%0d_pc", i), bus.pc_o, vq[i].pc);
      chk($sformatf("v%0d_insn", i), bus.instruction_o, vq[i].vld ? mem_word(vq[i].pc) : NOP);
      chk($sformatf("v%0d_mis", i), {31'd0, bus.misaligned_o}, 32'd0);
      if (vq[i].req) chk($sformatf("v%0d_addr", i), bus.imem_addr_o, vq[i].addr);
    end
    bus.redirect_i = 1'b0;

    // 3-cycle memory, redirect while fetching 0x8 goes through FLUSH
    mem_lat = 3;
    do_reset();
    bus.ins_ready_i = 1'b1;
    tick();
    wait_valid(10);
    chk("lat_pc0", bus.pc_o, 32'h0);
    tick();
    wait_valid(10);
    chk("lat_pc4", bus.pc_o, 32'h4);
    tick();
    chk("lat_addr8", bus.imem_addr_o, 32'h8);
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'h100;
    tick();
    bus.redirect_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("flush%0d_req", i), {31'd0, bus.imem_req_o}, 32'd1);
      chk($sformatf("flush%0d_addr", i), bus.imem_addr_o, 32'h8);
      chk($sformatf("flush%0d_valid", i), {31'd0, bus.ins_valid_o}, 32'd0);
      tick();
    end
    chk("flush_next_addr", bus.imem_addr_o, 32'h100);
    chk("flush_next_valid", {31'd0, bus.ins_valid_o}, 32'd0);
    chk("flush_cnt", bus.fetch_count_o, 32'd2);
    wait_valid(10);
    chk("flush_pc", bus.pc_o, 32'h100);
    chk("flush_insn", bus.instruction_o, mem_word(32'h100));

    // misaligned redirect from HOLD, then asynchronous reset
    bus.ins_ready_i = 1'b0;
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'h102;
    tick();
    bus.redirect_i = 1'b0;
    chk("mis_flag", {31'd0, bus.misaligned_o}, 32'd1);
    chk("mis_valid", {31'd0, bus.ins_valid_o}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("fault%0d_req", i), {31'd0, bus.imem_req_o}, 32'd0);
      chk($sformatf("fault%0d_mis", i), {31'd0, bus.misaligned_o}, 32'd1);
    end
    #2;
    reset_i = 1'b1;
    #1;
    chk("arst_mis", {31'd0, bus.misaligned_o}, 32'd0);
    chk("arst_addr", bus.imem_addr_o, 32'h0);
    chk("arst_cnt", bus.fetch_count_o, 32'd0);
    chk("arst_req", {31'd0, bus.imem_req_o}, 32'd0);
    tick();
    reset_i = 1'b0;
    tick();
    chk("restart_req", {31'd0, bus.imem_req_o}, 32'd1);
    chk("restart_addr", bus.imem_addr_o, 32'h0);

    // PC wrap from 0xFFFF_FFFC
    mem_lat = 0;
    do_reset();
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'hFFFF_FFFC;
    tick();
    bus.redirect_i = 1'b0;
    chk("wrap_addr", bus.imem_addr_o, 32'hFFFF_FFFC);
    tick();
    chk("wrap_valid", {31'd0, bus.ins_valid_o}, 32'd1);
    chk("wrap_pc", bus.pc_o, 32'hFFFF_FFFC);
    chk("wrap_insn", bus.instruction_o, mem_word(32'hFFFF_FFFC));
    bus.ins_ready_i = 1'b1;
    tick();
    chk("wrap_next_addr", bus.imem_addr_o, 32'h0);
    chk("wrap_next_req", {31'd0, bus.imem_req_o}, 32'd1);
    chk("wrap_cnt", bus.fetch_count_o, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
